// File: rtl/cc_arb_pkg.sv
// Shared types and defaults for the cc bus arbiter: FSM state encoding and owner ids.
// No logic. Combinational users only, so there is no latency and no backpressure.
package cc_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    XFER  = 2'd2,
    TURN  = 2'd3
  } cc_arb_state_t;

  localparam logic OWNER_A = 1'b0;
  localparam logic OWNER_B = 1'b1;

  localparam int CC_BURST_LEN_DFLT = 4;
  localparam int CC_DATA_W_DFLT    = 8;

endpackage

// File: rtl/cc_bus_arbiter_if.sv
// Source and bus-side signal bundle of the cc arbiter; the slave modport is the arbiter's view.
// Wiring only. Backpressure is carried by bus_ready, and each beat is accepted by ack_a or ack_b.
interface cc_bus_arbiter_if
  import cc_arb_pkg::*;
#(
  parameter int DATA_W = CC_DATA_W_DFLT
);
  logic              arb_en;
  logic              req_a;
  logic              req_b;
  logic [DATA_W-1:0] data_a;
  logic [DATA_W-1:0] data_b;
  logic              bus_ready;
  logic              gnt_a;
  logic              gnt_b;
  logic              ack_a;
  logic              ack_b;
  logic              bus_valid;
  logic [DATA_W-1:0] bus_data;
  logic              bus_sel;
  logic              bus_busy;

  modport slave (
    input  arb_en, req_a, req_b, data_a, data_b, bus_ready,
    output gnt_a, gnt_b, ack_a, ack_b, bus_valid, bus_data, bus_sel, bus_busy
  );

  modport master (
    output arb_en, req_a, req_b, data_a, data_b, bus_ready,
    input  gnt_a, gnt_b, ack_a, ack_b, bus_valid, bus_data, bus_sel, bus_busy
  );
endinterface

// File: rtl/cc_rr_pick.sv
// Two-way round-robin pick: a lone requester wins, and a tie goes to ptr. Purely combinational.
// No backpressure. The parent decides when the pick is consumed and holds the pointer register.
module cc_rr_pick
  import cc_arb_pkg::*;
(
  input  logic req_a,
  input  logic req_b,
  input  logic ptr,
  output logic any,
  output logic winner
);

  assign any    = req_a | req_b;
  assign winner = (req_a && req_b) ? ptr : (req_b ? OWNER_B : OWNER_A);

endmodule

// File: rtl/cc_bus_arbiter.sv
// Round-robin burst arbiter for the cc bus: grant at t+1, first beat at t+2, one turnaround cycle.
// bus_ready low stalls the beat. valid, data and beat_cnt hold, and no ack is issued.
module cc_bus_arbiter
  import cc_arb_pkg::*;
#(
  parameter int BURST_LEN = CC_BURST_LEN_DFLT,
  parameter int DATA_W    = CC_DATA_W_DFLT
)(
  input  logic             clk,
  input  logic             rst_n,
  cc_bus_arbiter_if.slave  bus
);

  localparam int              CNT_W     = $clog2(BURST_LEN + 1);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);

  cc_arb_state_t    r_state;
  cc_arb_state_t    w_state_nxt;
  logic             r_ptr;
  logic             r_sel;
  logic [CNT_W-1:0] r_beat_cnt;

  logic              w_any;
  logic              w_winner;
  logic              w_start;
  logic              w_beat_ok;
  logic [DATA_W-1:0] w_data;

  cc_rr_pick u_pick (
    .req_a  (bus.req_a),
    .req_b  (bus.req_b),
    .ptr    (r_ptr),
    .any    (w_any),
    .winner (w_winner)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_beat_ok   = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (bus.arb_en && w_any) begin
          w_start     = 1'b1;
          w_state_nxt = GRANT;
        end
      end
      GRANT: w_state_nxt = XFER;
      XFER: begin
        w_beat_ok = bus.bus_ready;
        if (w_beat_ok && (r_beat_cnt == LAST_BEAT)) begin
          w_state_nxt = TURN;
        end
      end
      TURN:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Owner and pointer are captured only at the IDLE->GRANT decision, so requests that drop mid-burst are ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_ptr      <= OWNER_A;
      r_sel      <= OWNER_A;
      r_beat_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_start) begin
        r_sel      <= w_winner;
        r_ptr      <= ~w_winner;
        r_beat_cnt <= '0;
      end else if (w_beat_ok && (r_beat_cnt != LAST_BEAT)) begin
        r_beat_cnt <= r_beat_cnt + CNT_W'(1);
      end
    end
  end

  assign w_data = (r_state == XFER) ? ((r_sel == OWNER_B) ? bus.data_b : bus.data_a) : '0;

  assign bus.gnt_a     = (r_state == GRANT) && (r_sel == OWNER_A);
  assign bus.gnt_b     = (r_state == GRANT) && (r_sel == OWNER_B);
  assign bus.ack_a     = w_beat_ok && (r_sel == OWNER_A);
  assign bus.ack_b     = w_beat_ok && (r_sel == OWNER_B);
  assign bus.bus_valid = (r_state == XFER);
  assign bus.bus_data  = w_data;
  assign bus.bus_sel   = r_sel;
  assign bus.bus_busy  = (r_state != IDLE);

endmodule

// File: tb/tb_cc_bus_arbiter.sv
// Directed scoreboard bench for cc_bus_arbiter: stimulus queues expected grant/ack events and a negedge monitor checks them.
module tb_cc_bus_arbiter;
  import cc_arb_pkg::*;

  localparam int BL = 4;
  localparam int DW = 8;

  typedef struct packed {
    int          cyc;
    logic        is_gnt;
    logic        owner;
    logic [7:0]  data;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  exp_t sb[$];

  cc_bus_arbiter_if #(.DATA_W(DW)) bif ();

  cc_bus_arbiter #(.BURST_LEN(BL), .DATA_W(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Source model: each accepted beat advances that source's data just after the edge.
  initial begin : src
    logic tk_a;
    logic tk_b;
    forever begin
      @(negedge clk);
      tk_a = bif.ack_a;
      tk_b = bif.ack_b;
      @(posedge clk);
      #1;
      if (tk_a) bif.data_a = bif.data_a + 8'd1;
      if (tk_b) bif.data_b = bif.data_b + 8'd1;
    end
  end

  always @(negedge clk) begin : mon
    exp_t e;
    logic ok;
    logic act_gnt;
    logic act_own;
    if (rst_n && (bif.gnt_a || bif.gnt_b || bif.ack_a || bif.ack_b)) begin
      n_cmp++;
      act_gnt = bif.gnt_a | bif.gnt_b;
      act_own = bif.gnt_b | bif.ack_b;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL sb_unexpected cyc=%0d gnt=%b%b ack=%b%b data=%h, required no event",
                 cyc, bif.gnt_a, bif.gnt_b, bif.ack_a, bif.ack_b, bif.bus_data);
      end else begin
        e  = sb.pop_front();
        ok = (cyc == e.cyc) && (act_gnt == e.is_gnt) && (act_own == e.owner) &&
             (bif.bus_sel == e.owner) && !(bif.gnt_a && bif.gnt_b) &&
             !(bif.ack_a && bif.ack_b) && !(act_gnt && (bif.ack_a || bif.ack_b));
        if (e.is_gnt) ok = ok && !bif.bus_valid;
        else          ok = ok && bif.bus_valid && (bif.bus_data == e.data);
        if (!ok) begin
          n_err++;
          $display("FAIL sb_event got cyc=%0d gnt=%b%b ack=%b%b sel=%b vld=%b data=%h; need cyc=%0d gnt=%b owner=%b data=%h",
                   cyc, bif.gnt_a, bif.gnt_b, bif.ack_a, bif.ack_b, bif.bus_sel, bif.bus_valid,
                   bif.bus_data, e.cyc, e.is_gnt, e.owner, e.data);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int n);
    while (cyc < n) step();
  endtask

  task automatic sample();
    #3;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%0h need=%0h", nm, cyc, act, req);
    end
  endtask

  task automatic push_ev(input int c, input logic g, input logic o, input logic [7:0] d);
    exp_t e;
    e.cyc    = c;
    e.is_gnt = g;
    e.owner  = o;
    e.data   = d;
    sb.push_back(e);
  endtask

  task automatic push_burst(input int g, input logic o, input logic [7:0] base);
    push_ev(g, 1'b1, o, 8'h00);
    for (int i = 0; i < BL; i++) push_ev(g + 1 + i, 1'b0, o, base + 8'(i));
  endtask

  initial begin : stim
    int c;
    bif.arb_en    = 1'b0;
    bif.req_a     = 1'b0;
    bif.req_b     = 1'b0;
    bif.data_a    = 8'h00;
    bif.data_b    = 8'h00;
    bif.bus_ready = 1'b0;

    // Reset state
    repeat (2) step();
    sample();
    chk("rst_ctrl_outs", 32'({bif.gnt_a, bif.gnt_b, bif.ack_a, bif.ack_b,
                              bif.bus_valid, bif.bus_busy, bif.bus_sel}), 32'd0);
    chk("rst_bus_data", 32'(bif.bus_data), 32'd0);
    chk("rst_state", 32'(dut.r_state), 32'(IDLE));
    chk("rst_ptr", 32'(dut.r_ptr), 32'(OWNER_A));
    chk("rst_beat_cnt", 32'(dut.r_beat_cnt), 32'd0);
    rst_n = 1'b1;
    step();

    // Lone B request with pointer at A
    c = cyc;
    bif.arb_en = 1'b1; bif.bus_ready = 1'b1;
    bif.data_b = 8'h40; bif.req_b = 1'b1;
    push_burst(c + 1, OWNER_B, 8'h40);
    wait_until(c + 1);
    bif.req_b = 1'b0;
    sample();
    chk("lone_b_ptr", 32'(dut.r_ptr), 32'(OWNER_A));
    chk("lone_b_sel", 32'(bif.bus_sel), 32'(OWNER_B));
    wait_until(c + 7);
    sample();
    chk("lone_b_idle_busy", 32'(bif.bus_busy), 32'd0);

    // Both requesting: A, B, A, B every 7 cycles
    c = cyc;
    bif.data_a = 8'h20; bif.data_b = 8'h80;
    bif.req_a = 1'b1; bif.req_b = 1'b1;
    push_burst(c + 1,  OWNER_A, 8'h20);
    push_burst(c + 8,  OWNER_B, 8'h80);
    push_burst(c + 15, OWNER_A, 8'h24);
    push_burst(c + 22, OWNER_B, 8'h84);
    wait_until(c + 22);
    bif.req_a = 1'b0; bif.req_b = 1'b0;
    wait_until(c + 28);
    sample();
    chk("rr_end_busy", 32'(bif.bus_busy), 32'd0);
    chk("rr_end_ptr", 32'(dut.r_ptr), 32'(OWNER_A));

    // Basic A burst from 0x10
    c = cyc;
    bif.data_a = 8'h10; bif.req_a = 1'b1;
    push_burst(c + 1, OWNER_A, 8'h10);
    wait_until(c + 1);
    bif.req_a = 1'b0;
    sample();
    chk("a_ptr_to_b", 32'(dut.r_ptr), 32'(OWNER_B));
    wait_until(c + 6);
    sample();
    chk("a_turn_busy_vld", 32'({bif.bus_busy, bif.bus_valid}), 32'b10);
    wait_until(c + 7);
    sample();
    chk("a_idle_busy", 32'(bif.bus_busy), 32'd0);

    // bus_ready stall for 3 cycles on the second beat
    c = cyc;
    bif.data_a = 8'h50; bif.req_a = 1'b1;
    push_ev(c + 1, 1'b1, OWNER_A, 8'h00);
    push_ev(c + 2, 1'b0, OWNER_A, 8'h50);
    push_ev(c + 6, 1'b0, OWNER_A, 8'h51);
    push_ev(c + 7, 1'b0, OWNER_A, 8'h52);
    push_ev(c + 8, 1'b0, OWNER_A, 8'h53);
    wait_until(c + 1);
    bif.req_a = 1'b0;
    for (int k = 3; k <= 5; k++) begin
      wait_until(c + k);
      if (k == 3) bif.bus_ready = 1'b0;
      sample();
      chk("stall_vld_ack", 32'({bif.bus_valid, bif.ack_a}), 32'b10);
      chk("stall_beat_cnt", 32'(dut.r_beat_cnt), 32'd1);
      chk("stall_data", 32'(bif.bus_data), 32'h51);
    end
    wait_until(c + 6);
    bif.bus_ready = 1'b1;
    wait_until(c + 10);
    sample();
    chk("stall_idle_busy", 32'(bif.bus_busy), 32'd0);

    // req_a and arb_en dropped mid-burst; then arb_en=0 blocks req_b
    c = cyc;
    bif.data_a = 8'h60; bif.req_a = 1'b1;
    push_burst(c + 1, OWNER_A, 8'h60);
    wait_until(c + 2);
    bif.req_a = 1'b0; bif.arb_en = 1'b0;
    wait_until(c + 7);
    bif.req_b = 1'b1;
    for (int k = 7; k <= 11; k++) begin
      wait_until(c + k);
      sample();
      chk("no_arb_en_grant", 32'({bif.gnt_b, bif.bus_busy}), 32'd0);
    end
    step();
    bif.req_b = 1'b0; bif.arb_en = 1'b1;
    step();

    // Asynchronous reset during beat 3
    c = cyc;
    bif.data_a = 8'h70; bif.req_a = 1'b1;
    push_ev(c + 1, 1'b1, OWNER_A, 8'h00);
    push_ev(c + 2, 1'b0, OWNER_A, 8'h70);
    push_ev(c + 3, 1'b0, OWNER_A, 8'h71);
    wait_until(c + 1);
    bif.req_a = 1'b0;
    wait_until(c + 4);
    #1;
    chk("mid_rst_pre_vld", 32'(bif.bus_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_outs", 32'({bif.bus_valid, bif.ack_a, bif.ack_b, bif.bus_busy,
                             bif.gnt_a, bif.gnt_b}), 32'd0);
    wait_until(c + 5);
    rst_n = 1'b1;
    sample();
    chk("post_rst_state", 32'(dut.r_state), 32'(IDLE));
    chk("post_rst_ptr", 32'(dut.r_ptr), 32'(OWNER_A));
    chk("post_rst_cnt_sel", 32'({dut.r_beat_cnt, bif.bus_sel}), 32'd0);

    repeat (3) step();
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/cc_bus_arbiter.md
# cc_bus_arbiter

Two-requester, round-robin arbiter and sequencer for the shared 8-bit `cc` control/data bus. It grants bus ownership to one of two sources for a fixed-length burst, drives the owner's data onto the bus beat by beat under a valid/ready handshake, and inserts a one-cycle turnaround between owners. It sits between the requesting sources and the combinational `cc` bus-control logic, and generates that logic's enable and select strobes.

## Interface
- `BURST_LEN`, default 4: beats per grant; legal range 1..16.
- `DATA_W`, default 8: bus data width.

- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `arb_en`  in  1  arbitration enable; sampled only in IDLE.
- `req_a`, `req_b`  in  1  source requests; level, held until the matching grant.
- `data_a`, `data_b`  in  DATA_W  source beat data; must be valid while that source owns the bus.
- `bus_ready`  in  1  downstream accepts the current beat.
- `gnt_a`, `gnt_b`  out  1  one-cycle grant pulse in GRANT.
- `ack_a`, `ack_b`  out  1  beat-accepted pulse to the owner; the source advances its data on this pulse.
- `bus_valid`  out  1  beat present on `bus_data`.
- `bus_data`  out  DATA_W  owner's data, muxed by the registered owner.
- `bus_sel`  out  1  current owner: 0 = A, 1 = B.
- `bus_busy`  out  1  high in GRANT, XFER and TURN.

## Operation
- States:
  - IDLE: if `arb_en` and any request, pick the owner, then go to GRANT; otherwise stay in IDLE.
  - GRANT: one cycle; pulse `gnt_<owner>`; go to XFER.
  - XFER: `bus_valid`=1; a beat is accepted when `bus_ready`=1, which pulses `ack_<owner>` and increments `beat_cnt`. When the beat with `beat_cnt==BURST_LEN-1` is accepted, go to TURN.
  - TURN: one cycle; no valid, no grant; go to IDLE.
- Owner pick:
  - With a single request, that requester wins regardless of the pointer.
  - With both requesting, the priority pointer wins.
  - The pointer moves to the non-winner when the grant is issued.
  - The pointer resets to A.
- `beat_cnt` is $clog2(BURST_LEN+1) bits wide. It clears on entry to GRANT and never wraps past BURST_LEN-1.
- A burst always completes:
  - Dropping `req_x` or `arb_en` during GRANT, XFER or TURN has no effect.
  - `bus_ready` stalling holds `bus_valid`, `bus_data` (tracking the owner's input) and `beat_cnt`.
- `bus_sel` updates when entering GRANT and holds through TURN. In IDLE it keeps its last value.
- Outputs in IDLE: `bus_valid`=0, all grants and acks 0, `bus_data`=0.

## Timing
- Reset values (asynchronous): state=IDLE, pointer=A, `beat_cnt`=0, `bus_sel`=0. Every other output is 0.
- State, `bus_sel`, `beat_cnt` and the pointer are registered. `gnt_*`, `bus_valid`, `bus_busy` and `ack_*` decode from registered state plus `bus_ready`. `bus_data` is a mux of inputs.
- Cycle sequence:
  - Request seen in IDLE at cycle t.
  - `gnt` at t+1.
  - First `bus_valid` at t+2.
  - With `bus_ready` tied high, the last beat is at t+1+BURST_LEN, TURN at t+2+BURST_LEN, IDLE at t+3+BURST_LEN.
- Minimum grant period: BURST_LEN+3 cycles. A pending second requester is granted at the IDLE that follows TURN.
- Reset asserted mid-burst: all outputs drop immediately with no completion, and the pointer returns to A.
- `req_x` asserted in GRANT/XFER/TURN: held by the source, seen at the next IDLE.

## Structure
- Package `cc_arb_pkg`:
  - state enum `cc_arb_state_t` {IDLE, GRANT, XFER, TURN};
  - owner constants `OWNER_A`=1'b0, `OWNER_B`=1'b1;
  - default `BURST_LEN`.
- Sub-module `cc_rr_pick`: combinational 2-way round-robin selector. Inputs: `req_a`, `req_b`, `ptr`. Outputs: `any`, `winner`. The pointer register stays in the parent.
- Top: state register, beat counter, owner register, output decode and data mux.

## Test plan
- Reset, then `req_a`=1, `arb_en`=1, `bus_ready`=1, `BURST_LEN`=4, `data_a` incrementing from 0x10:
  - `gnt_a` at cycle 1;
  - `bus_valid` for cycles 2–5 with `bus_data` 0x10, 0x11, 0x12, 0x13;
  - four `ack_a` pulses;
  - `bus_busy` low at cycle 7.
- `req_a` and `req_b` both held high: grant order A, B, A, B; each grant exactly 7 cycles apart; `bus_sel` toggles at each GRANT.
- Only `req_b` while the pointer is at A: B granted at once; the pointer then moves to A.
- `bus_ready` low for 3 cycles during beat 2: `bus_valid` stays high, `beat_cnt` holds at 1, no `ack`; the burst completes with exactly 4 acks.
- `req_a` dropped and `arb_en`=0 during XFER: the burst still completes. With `arb_en`=0 in IDLE and `req_b`=1, no grant occurs.
- `rst_n` pulsed low during beat 3: `bus_valid`, `ack_*` and `bus_busy` go to 0 asynchronously. After release, the state is IDLE and the pointer is A.
